instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer that owns the PC and IR and steps the existing combinational decoder/datapath through FETCH, DECODE, EXECUTE and WRITEBACK. It fetches over a req/ack instruction-memory handshake, latches the instruction word, and gates the decoder's register byte-write controls so they act only in WRITEBACK. It computes the next PC from the decoder's jump and branch outputs. It sits between instruction memory and the decoder/ALU/register-file datapath.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- run  in  1  while high, the sequencer starts a new fetch after each retire.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; always equals pc.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- ir  out  32  latched instruction; drives the decoder's IR input.
- pc  out  32  current instruction address.
- dec_jump  in  1  decoder Jump.
- dec_cond  in  3  decoder condition; 3'b000 means no branch.
- cmp_taken  in  1  datapath comparator result for dec_cond; valid in EXECUTE.
- dec_byte_w_en  in  4  decoder Rd_byte_w_en, in decoder convention: bit = 1 inhibits that byte.
- rf_byte_w_en  out  4  gated register-file byte write controls, same convention.
- retire  out  1  one-cycle pulse when an instruction completes.
- retire_cnt  out  32  count of retired instructions.
- state  out  3  current FSM state, for debug.

## Operation
- FSM states:
  - IDLE (3'd0)
  - FETCH (3'd1)
  - DECODE (3'd2)
  - EXECUTE (3'd3)
  - WRITEBACK (3'd4)
- IDLE: moves to FETCH when run = 1; otherwise stays in IDLE.
- FETCH: imem_req = 1. It holds until imem_ack = 1 is sampled; on that edge, ir <= imem_rdata and the FSM moves to DECODE. imem_ack is ignored in every other state.
- DECODE: one cycle for decoder outputs to settle; the FSM then moves to EXECUTE.
- EXECUTE: taken_q <= (dec_cond != 0) & cmp_taken; the FSM then moves to WRITEBACK.
- WRITEBACK:
  - rf_byte_w_en = dec_byte_w_en; in every other state rf_byte_w_en = 4'b1111 (all writes inhibited).
  - pc updates as follows:
    - if dec_jump: pc <= {pc_plus4[31:28], ir[25:0], 2'b00}.
    - else if taken_q: pc <= pc_plus4 + {{14{ir[15]}}, ir[15:0], 2'b00}.
    - else: pc <= pc_plus4.
    - pc_plus4 = pc + 4.
  - retire = 1, and retire_cnt increments.
  - next state is FETCH if run = 1, else IDLE.
- There are no delay slots. jump takes priority over branch.
- All PC arithmetic is 32-bit modulo 2^32: pc 32'hFFFF_FFFC wraps to 0, and retire_cnt wraps from 32'hFFFF_FFFF to 0.
- Dropping run mid-instruction does not abort it; the sequencer stops after WRITEBACK.

## Timing
- Reset (rst_n = 0 at an edge) forces:
  - state = IDLE, pc = RESET_PC, ir = 0, taken_q = 0, retire_cnt = 0.
  - imem_req = 0, retire = 0, rf_byte_w_en = 4'b1111.
- Reset is honored in every state. A reset during FETCH drops imem_req on the next cycle, and an ack arriving in that cycle is discarded.
- imem_req, rf_byte_w_en and retire are Moore outputs decoded from state only.
- Latency: a zero-wait ack (ack in the first FETCH cycle) gives 4 cycles per instruction (FETCH, DECODE, EXECUTE, WRITEBACK). Each wait cycle adds 1.
- Back-to-back execution: WRITEBACK is followed by FETCH with no IDLE bubble while run = 1.
- From IDLE, the first imem_req rises 1 cycle after run is sampled high.
- The new pc is visible on imem_addr in the first cycle of the following FETCH.

## Structure
- A shared package holds:
  - state encodings SEQ_IDLE … SEQ_WB as 3-bit localparams.
  - W_INHIBIT = 4'b1111.
  - the COND_NONE = 3'b000 encoding, shared with the decoder.
- One combinational sub-module, next_pc, takes pc, ir, dec_jump and taken_q and outputs the next pc. It is reused by the future pipelined front end.

## Test plan
- Reset/start: hold rst_n = 0 for 2 cycles, then raise run with ack tied high. pc = 0, imem_req is first seen 1 cycle after run, first retire at cycle 4, retire_cnt = 1.
- Wait states: ack delayed 3 cycles with ir word 32'h2008_0005 (ADDI). retire comes 7 cycles after FETCH entry; rf_byte_w_en equals dec_byte_w_en only in the WRITEBACK cycle and is 4'b1111 in all others.
- Taken branch: pc = 32'h100, ir = 32'h1000_FFFE (BEQ offset −2), dec_cond = 3'b001, cmp_taken = 1. Next pc = 32'h0FC. With cmp_taken = 0, next pc = 32'h104.
- Jump: pc = 32'h8000_0010, ir = 32'h0800_0040. Next pc = 32'h8000_0100, regardless of cmp_taken.
- Stop and wrap:
  - Drop run during DECODE: the FSM completes WRITEBACK, enters IDLE and issues no further imem_req.
  - Preload pc = 32'hFFFF_FFFC with a non-branch instruction: next pc = 0.
- Mid-fetch reset: assert rst_n = 0 while in FETCH and pulse ack in the same cycle. ir stays 0, state = IDLE, retire_cnt = 0.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: state encodings and write-control constants shared with the decoder
package instr_sequencer_pkg;
    localparam logic [2:0] SEQ_IDLE   = 3'd0;
    localparam logic [2:0] SEQ_FETCH  = 3'd1;
    localparam logic [2:0] SEQ_DECODE = 3'd2;
    localparam logic [2:0] SEQ_EXEC   = 3'd3;
    localparam logic [2:0] SEQ_WB     = 3'd4;
    localparam logic [3:0] W_INHIBIT  = 4'b1111;
    localparam logic [2:0] COND_NONE  = 3'b000;
    typedef enum logic [2:0] {
        S_IDLE   = SEQ_IDLE,
        S_FETCH  = SEQ_FETCH,
        S_DECODE = SEQ_DECODE,
        S_EXEC   = SEQ_EXEC,
        S_WB     = SEQ_WB
    } seq_state_t;
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction-memory req/ack fetch bus
interface instr_sequencer_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;
    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/instr_sequencer_next_pc.sv
// instr_sequencer_next_pc: next PC from jump target, taken branch offset or sequential step
module instr_sequencer_next_pc (
    input  logic [31:0] pc,
    input  logic [25:0] target,
    input  logic        jump,
    input  logic        taken,
    output logic [31:0] next_pc
);
    logic [31:0] pc_plus4;
    assign pc_plus4 = pc + 32'd4;
    assign next_pc = jump  ? {pc_plus4[31:28], target, 2'b00} :
                     taken ? pc_plus4 + {{14{target[15]}}, target[15:0], 2'b00} :
                             pc_plus4;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK control owning PC and IR
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      run,
    instr_sequencer_if.master         imem,
    output logic [31:0]               ir,
    output logic [31:0]               pc,
    input  logic                      dec_jump,
    input  logic [2:0]                dec_cond,
    input  logic                      cmp_taken,
    input  logic [3:0]                dec_byte_w_en,
    output logic [3:0]                rf_byte_w_en,
    output logic                      retire,
    output logic [31:0]               retire_cnt,
    output logic [2:0]                state
);
    seq_state_t  cur, nxt;
    logic        taken_q;
    logic [31:0] npc;

    instr_sequencer_next_pc u_next_pc (
        .pc(pc),
        .target(ir[25:0]),
        .jump(dec_jump),
        .taken(taken_q),
        .next_pc(npc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur        <= S_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            taken_q    <= 1'b0;
            retire_cnt <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_FETCH && imem.ack) ir <= imem.rdata;
            if (cur == S_EXEC) taken_q <= (dec_cond != COND_NONE) & cmp_taken;
            if (cur == S_WB) begin
                pc         <= npc;
                retire_cnt <= retire_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:   nxt = run ? S_FETCH : S_IDLE;
            S_FETCH:  nxt = imem.ack ? S_DECODE : S_FETCH;
            S_DECODE: nxt = S_EXEC;
            S_EXEC:   nxt = S_WB;
            S_WB:     nxt = run ? S_FETCH : S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // register-file writes are only allowed to land in WRITEBACK
    assign rf_byte_w_en = (cur == S_WB) ? dec_byte_w_en : W_INHIBIT;
    assign retire       = (cur == S_WB);
    assign imem.req     = (cur == S_FETCH);
    assign imem.addr    = pc;
    assign state        = cur;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed + random stimulus checked against an instruction-level model
module tb_instr_sequencer;
    logic        clk = 0, rst_n = 0, run = 0, ack = 0;
    logic [31:0] rdata = 0;
    logic        dec_jump = 0, cmp_taken = 0;
    logic [2:0]  dec_cond = 0;
    logic [3:0]  dec_byte_w_en = 0;
    logic [31:0] ir, pc, retire_cnt;
    logic [3:0]  rf_byte_w_en;
    logic        retire;
    logic [2:0]  state;
    int          checks = 0, errors = 0;
    bit          cmp_en = 0;

    instr_sequencer_if imem_bus();
    assign imem_bus.ack   = ack;
    assign imem_bus.rdata = rdata;

    instr_sequencer #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .imem(imem_bus),
        .ir(ir), .pc(pc), .dec_jump(dec_jump), .dec_cond(dec_cond),
        .cmp_taken(cmp_taken), .dec_byte_w_en(dec_byte_w_en),
        .rf_byte_w_en(rf_byte_w_en), .retire(retire),
        .retire_cnt(retire_cnt), .state(state)
    );

    logic [31:0] np_pc = 0, np_out;
    logic [25:0] np_target = 0;
    logic        np_jump = 0, np_taken = 0;
    instr_sequencer_next_pc u_np (
        .pc(np_pc), .target(np_target), .jump(np_jump), .taken(np_taken), .next_pc(np_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] i,
                                               input bit j, input bit t);
        logic [31:0] p4, off;
        p4  = p + 32'd4;
        off = {{16{i[15]}}, i[15:0]};
        if (j) return (p4 & 32'hF000_0000) | ((i & 32'h03FF_FFFF) << 2);
        if (t) return p4 + (off << 2);
        return p4;
    endfunction

    // m_fetch: waiting on ack; m_step: cycles elapsed since the ack edge (3 = writeback cycle)
    bit          m_fetch = 0, m_tk = 0;
    int          m_step = 0;
    logic [31:0] m_pc = 0, m_ir = 0, m_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_fetch = 0; m_step = 0; m_pc = 0; m_ir = 0; m_cnt = 0; m_tk = 0;
        end else if (m_step == 3) begin
            m_pc = model_next(m_pc, m_ir, dec_jump, m_tk);
            m_cnt = m_cnt + 1;
            m_step = 0;
            m_fetch = run;
        end else if (m_step > 0) begin
            if (m_step == 2) m_tk = (dec_cond != 0) && cmp_taken;
            m_step++;
        end else if (m_fetch) begin
            if (ack) begin
                m_ir = rdata; m_fetch = 0; m_step = 1;
            end
        end else m_fetch = run;
    end

    always @(negedge clk) if (cmp_en) begin
        chk("imem_req", 32'(imem_bus.req), 32'(m_fetch));
        chk("imem_addr", imem_bus.addr, m_pc);
        chk("pc", pc, m_pc);
        chk("ir", ir, m_ir);
        chk("retire", 32'(retire), 32'(m_step == 3));
        chk("retire_cnt", retire_cnt, m_cnt);
        chk("rf_byte_w_en", 32'(rf_byte_w_en), 32'(m_step == 3 ? dec_byte_w_en : 4'b1111));
        chk("state", 32'(state), m_fetch ? 32'd1 : (m_step == 0 ? 32'd0 : 32'(m_step + 1)));
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [31:0] w, input logic j, input logic [2:0] c,
                            input logic t, input logic [3:0] b);
        rdata = w; ack = 1; dec_jump = j; dec_cond = c; cmp_taken = t; dec_byte_w_en = b;
        repeat (3) cyc();
        ack = 0;
    endtask

    initial begin
        int n;
        repeat (2) cyc();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_cnt", retire_cnt, 32'h0);
        chk("rst_req", 32'(imem_bus.req), 32'd0);
        chk("rst_rf", 32'(rf_byte_w_en), 32'hF);
        chk("rst_retire", 32'(retire), 32'd0);
        cmp_en = 1;
        rst_n = 1; run = 1; ack = 1;
        cyc();
        chk("req_after_run", 32'(imem_bus.req), 32'd1);
        cyc(); cyc();
        chk("no_retire_c3", 32'(retire), 32'd0);
        cyc();
        chk("retire_c4", 32'(retire), 32'd1);
        run = 0; ack = 0;
        cyc();
        chk("first_cnt", retire_cnt, 32'd1);
        chk("first_pc", pc, 32'd4);
        chk("first_idle", 32'(state), 32'd0);

        rdata = 32'h2008_0005; dec_byte_w_en = 4'b1100; run = 1; ack = 0;
        cyc();
        n = 1;
        while (!retire && n < 20) begin
            chk("wait_rf_inhibit", 32'(rf_byte_w_en), 32'hF);
            ack = (n == 4);
            cyc();
            n++;
        end
        chk("wait_latency", n, 7);
        chk("wait_rf_wb", 32'(rf_byte_w_en), 32'hC);
        ack = 0;
        cyc();
        chk("b2b_fetch", 32'(state), 32'd1);
        chk("b2b_addr", imem_bus.addr, 32'd8);

        do_instr(32'h0800_0040, 1, 3'd0, 0, 4'hF);
        cyc();
        chk("jump_0x100", pc, 32'h100);
        do_instr(32'h1000_FFFE, 0, 3'd1, 1, 4'hF);
        cyc();
        chk("branch_taken", pc, 32'h0FC);
        do_instr(32'h0800_0040, 1, 3'd0, 1, 4'hF);
        cyc();
        chk("jump_back", pc, 32'h100);
        do_instr(32'h1000_FFFE, 0, 3'd1, 0, 4'hF);
        cyc();
        chk("branch_not_taken", pc, 32'h104);

        rdata = 0; dec_jump = 0; dec_cond = 0; ack = 1;
        cyc();
        run = 0; ack = 0;
        cyc(); cyc();
        chk("stop_retire", 32'(retire), 32'd1);
        cyc();
        chk("stop_idle", 32'(state), 32'd0);
        chk("stop_pc", pc, 32'h108);
        repeat (5) begin
            cyc();
            chk("stop_no_req", 32'(imem_bus.req), 32'd0);
        end
        chk("stop_cnt", retire_cnt, 32'd7);

        run = 1;
        cyc();
        chk("mf_in_fetch", 32'(imem_bus.req), 32'd1);
        rst_n = 0; ack = 1; rdata = 32'hDEAD_BEEF; run = 0;
        cyc();
        chk("mf_ir", ir, 32'h0);
        chk("mf_state", 32'(state), 32'd0);
        chk("mf_cnt", retire_cnt, 32'h0);
        chk("mf_req", 32'(imem_bus.req), 32'd0);
        rst_n = 1; ack = 0;

        for (int i = 0; i < 3000; i++) begin
            rst_n         = $urandom_range(0, 299) != 0;
            run           = $urandom_range(0, 7) != 0;
            ack           = $urandom_range(0, 1) != 0;
            rdata         = $urandom;
            dec_jump      = $urandom_range(0, 3) == 0;
            dec_cond      = 3'($urandom_range(0, 7));
            cmp_taken     = $urandom_range(0, 1) != 0;
            dec_byte_w_en = 4'($urandom_range(0, 15));
            cyc();
        end
        cmp_en = 0;

        np_pc = 32'h100; np_target = 26'h000_FFFE; np_jump = 0; np_taken = 1; #1;
        chk("np_branch_taken", np_out, 32'h0FC);
        np_taken = 0; #1;
        chk("np_branch_not_taken", np_out, 32'h104);
        np_pc = 32'h8000_0010; np_target = 26'h000_0040; np_jump = 1; np_taken = 0; #1;
        chk("np_jump", np_out, 32'h8000_0100);
        np_taken = 1; #1;
        chk("np_jump_over_branch", np_out, 32'h8000_0100);
        np_pc = 32'hFFFF_FFFC; np_target = 26'h000_0000; np_jump = 0; np_taken = 0; #1;
        chk("np_wrap", np_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
